// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexes the shared 7-segment decoder between the sign digit (an3)
// and the magnitude digit (an4). A blanking gap precedes each digit. The operand register
// only updates at frame boundaries, so both digits of a frame always show the same value.
module display_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLANK_CYC   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] Data_in,
    output logic [3:0] value,
    output logic       busy,
    output logic       load_ack,
    output logic       frame_tick,
    output logic       dig_sel,
    output logic       seg_en,
    output logic       an3,
    output logic       an4
);

    localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - BLANK_CYC - 1);

    typedef enum logic [1:0] {StBlank3, StShow3, StBlank4, StShow4} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic          w_slot_end;
    logic          w_boundary;

    logic          r_an3;
    logic          r_an4;
    logic          r_seg_en;
    logic          r_dig_sel;
    logic          r_frame_tick;
    logic [3:0]    r_value;
    logic [3:0]    r_shadow;
    logic          r_pending;
    logic          r_load_ack;

    // Slot-end detection and the successor state in the scan ring
    always_comb begin
        w_slot_end   = 1'b0;
        w_state_next = r_state;
        unique case (r_state)
            StBlank3: begin w_slot_end = (r_cnt == BLANK_LAST); w_state_next = StShow3;  end
            StShow3:  begin w_slot_end = (r_cnt == SHOW_LAST);  w_state_next = StBlank4; end
            StBlank4: begin w_slot_end = (r_cnt == BLANK_LAST); w_state_next = StShow4;  end
            StShow4:  begin w_slot_end = (r_cnt == SHOW_LAST);  w_state_next = StBlank3; end
            default:  begin w_slot_end = 1'b1;                  w_state_next = StBlank3; end
        endcase
    end

    assign w_boundary = (r_state == StShow4) && w_slot_end;

    // Scan FSM; outputs are registered alongside the state so they decode from it exactly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= StBlank3;
            r_cnt        <= '0;
            r_an3        <= 1'b1;
            r_an4        <= 1'b1;
            r_seg_en     <= 1'b0;
            r_dig_sel    <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_boundary;
            if (w_slot_end) begin
                r_cnt   <= '0;
                r_state <= w_state_next;
                unique case (w_state_next)
                    StBlank3: begin r_an3 <= 1'b1; r_an4 <= 1'b1; r_seg_en <= 1'b0; r_dig_sel <= 1'b1; end
                    StShow3:  begin r_an3 <= 1'b0; r_an4 <= 1'b1; r_seg_en <= 1'b1; r_dig_sel <= 1'b1; end
                    StBlank4: begin r_an3 <= 1'b1; r_an4 <= 1'b1; r_seg_en <= 1'b0; r_dig_sel <= 1'b0; end
                    StShow4:  begin r_an3 <= 1'b1; r_an4 <= 1'b0; r_seg_en <= 1'b1; r_dig_sel <= 1'b0; end
                    default:  begin r_an3 <= 1'b1; r_an4 <= 1'b1; r_seg_en <= 1'b0; r_dig_sel <= 1'b1; end
                endcase
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Operand capture: shadow mid-frame, apply at the boundary (a boundary load bypasses shadow)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_value    <= 4'd0;
            r_shadow   <= 4'd0;
            r_pending  <= 1'b0;
            r_load_ack <= 1'b0;
        end else if (w_boundary) begin
            if (load) begin
                r_value    <= Data_in;
                r_load_ack <= 1'b1;
                r_pending  <= 1'b0;
            end else if (r_pending) begin
                r_value    <= r_shadow;
                r_load_ack <= 1'b1;
                r_pending  <= 1'b0;
            end else begin
                r_load_ack <= 1'b0;
            end
        end else begin
            r_load_ack <= 1'b0;
            if (load) begin
                r_shadow  <= Data_in;
                r_pending <= 1'b1;
            end
        end
    end

    assign an3        = r_an3;
    assign an4        = r_an4;
    assign seg_en     = r_seg_en;
    assign dig_sel    = r_dig_sel;
    assign frame_tick = r_frame_tick;
    assign value      = r_value;
    assign busy       = r_pending;
    assign load_ack   = r_load_ack;

endmodule
